// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register with load-use hazard detection and flush/stall bubbles.
// Latency : 1 cycle from ID inputs to ex_* outputs; stall/pc_write/if_id_write are combinational.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle while a bubble enters EX.
//
// Ports:
//   clk, rst                  - single clock, synchronous active-high reset
//   id_instruc                - instruction in ID (register indices and funct fields are taken from it)
//   id_pc, id_rs1_data,
//   id_rs2_data, id_imm       - ID datapath values (XLEN bits)
//   id_ALUOp .. id_mem_to_reg - control-unit decode for id_instruc
//   flush                     - a later stage took a branch; the ID instruction is discarded
//   ex_*                      - registered EX-stage copies, ex_valid marks a real instruction
//   stall, pc_write,
//   if_id_write               - load-use hazard indication and upstream write enables
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     id_instruc,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [1:0]      id_ALUOp,
  input  logic            id_ALUSrc,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            flush,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [1:0]      ex_ALUOp,
  output logic            ex_ALUSrc,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_valid,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_30,
  output logic            stall,
  output logic            pc_write,
  output logic            if_id_write
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_30;
  } ex_regs_t;

  ex_regs_t ex_q;
  ex_regs_t ex_d;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       funct7_30;
  logic       rs1_used;
  logic       rs2_used;
  logic       hazard;

  // Bits of the instruction that this stage does not forward (funct7 except bit 30).
  logic       unused_instr_bits;

  assign opcode    = id_instruc[6:0];
  assign rd        = id_instruc[11:7];
  assign funct3    = id_instruc[14:12];
  assign rs1       = id_instruc[19:15];
  assign rs2       = id_instruc[24:20];
  assign funct7_30 = id_instruc[30];
  assign unused_instr_bits = ^{id_instruc[31], id_instruc[29:25]};

  // Only formats that really read a source register may cause a hazard; for
  // I-type/U-type/J-type the rs2 field is immediate bits and must be ignored.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      7'b0000011: rs1_used = 1'b1;                     // load
      7'b0010011: rs1_used = 1'b1;                     // ALU immediate
      7'b0100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end  // store
      7'b0110011: begin rs1_used = 1'b1; rs2_used = 1'b1; end  // ALU register
      7'b1100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end  // branch
      default:    ;
    endcase
  end

  // Load in EX whose destination is needed by ID: the value is not ready yet.
  // x0 is hardwired to zero, so a load to x0 never blocks anything.
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                  ((rs1_used && (ex_q.rd == rs1)) || (rs2_used && (ex_q.rd == rs2)));

  // A flush discards the dependent instruction anyway, so it must not also freeze PC.
  assign stall       = hazard && !flush;
  assign pc_write    = !stall;
  assign if_id_write = !stall;

  always_comb begin
    ex_d            = '0;
    ex_d.pc         = id_pc;
    ex_d.rs1_data   = id_rs1_data;
    ex_d.rs2_data   = id_rs2_data;
    ex_d.imm        = id_imm;
    ex_d.alu_op     = id_ALUOp;
    ex_d.alu_src    = id_ALUSrc;
    ex_d.branch     = id_branch;
    ex_d.mem_read   = id_mem_read;
    ex_d.mem_write  = id_mem_write;
    ex_d.reg_write  = id_reg_write;
    ex_d.mem_to_reg = id_mem_to_reg;
    ex_d.valid      = 1'b1;
    ex_d.rs1        = rs1;
    ex_d.rs2        = rs2;
    ex_d.rd         = rd;
    ex_d.funct3     = funct3;
    ex_d.funct7_30  = funct7_30;
  end

  // Reset, flush and stall all clear the whole register; the bubble clears
  // ex_mem_read, which is what limits a stall to a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_ALUOp      = ex_q.alu_op;
  assign ex_ALUSrc     = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_valid      = ex_q.valid;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_funct7_30  = ex_q.funct7_30;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, register operands and immediate.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port id_instruc  input  32  instruction currently in ID.
REQ-005 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  ID-stage PC, register-file reads and sign-extended immediate.
REQ-006 SHALL have ports id_ALUOp (2), id_ALUSrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg (1 each)  input  control-unit outputs for id_instruc.
REQ-007 SHALL have port flush  input  1  branch taken in a later stage; discard ID instruction.
REQ-008 SHALL have registered outputs ex_pc, ex_rs1_data, ex_rs2_data, ex_imm (XLEN), ex_ALUOp (2), ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_valid (1), ex_rs1, ex_rs2, ex_rd (5), ex_funct3 (3), ex_funct7_30 (1)  output  EX-stage copies.
REQ-009 SHALL have combinational outputs stall, pc_write, if_id_write  output  1 each  load-use hazard indication and upstream write enables.

Function
REQ-010 Field extraction SHALL be rs1=instruc[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], funct7_30=[30].
REQ-011 rs1 SHALL count as used for opcodes 0000011, 0100011, 0110011, 1100011, 0010011; rs2 SHALL count as used for 0100011, 0110011, 1100011 only.
REQ-012 hazard SHALL be ex_valid & ex_mem_read & (ex_rd != 0) & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
REQ-013 stall SHALL equal hazard & ~flush; pc_write and if_id_write SHALL equal ~stall.
REQ-014 Update priority on each rising edge SHALL be rst > flush > stall > normal load.
REQ-015 Normal load: every ex_* output SHALL take the corresponding id_* value/field one cycle later, ex_valid=1.
REQ-016 Bubble (flush or stall): every ex_* output including ex_valid, ex_rd and all data fields SHALL be loaded with 0.
REQ-017 A stall SHALL last exactly one cycle, since the bubble clears ex_mem_read.
REQ-018 flush and hazard in the same cycle SHALL yield stall=0, pc_write=1, and a bubble.
REQ-019 Latency ID to EX SHALL be exactly 1 cycle; no other internal state SHALL exist.
REQ-020 Register x0 SHALL never produce a hazard.

Reset
REQ-021 rst=1 at a rising edge SHALL load 0 into every registered output; stall SHALL read 0 in the following cycle.
REQ-022 rst asserted mid-stall SHALL override and discard the bubble/stall; upstream retries the instruction once rst drops.
REQ-023 Outputs SHALL not change between edges except the combinational stall/pc_write/if_id_write.

Verification
REQ-024 rst=1 for 2 edges with random inputs -> all ex_* = 0, ex_valid=0, stall=0, pc_write=1.
REQ-025 id_instruc=0x00308293 (addi x5,x1,3), id_imm=3, id_ALUSrc=1, id_reg_write=1 -> next edge ex_rd=5, ex_rs1=1, ex_imm=3, ex_ALUSrc=1, ex_reg_write=1, ex_valid=1, stall=0.
REQ-026 EX holds lw x5 (ex_mem_read=1, ex_rd=5); id_instruc=0x00728333 (add x6,x5,x7) -> stall=1, pc_write=0, if_id_write=0; next edge all ex controls 0; following cycle stall=0 and next edge ex_rd=6.
REQ-027 EX holds lw x5; id_instruc=0x00508313 (addi x6,x1,5, imm bits match 5) -> stall=0; EX holds lw x0, ID uses x0 -> stall=0.
REQ-028 EX holds lw x5, ID holds add x6,x5,x7, flush=1 -> stall=0, pc_write=1; next edge ex_valid=0, ex_reg_write=0.
REQ-029 Stall cycle with rst=1 -> next edge all outputs 0, stall=0.
